// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: envelope sequencer with repeat frames and carrier modulation.
// Define IR_NEC_TX_EXT_ADDR_EN for extended mode (second byte = addr[15:8] instead of ~addr[7:0]).
module ir_nec_tx #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned CARRIER_HZ   = 38_000,
    parameter int unsigned DUTY_PCT     = 30,
    parameter int unsigned REPEAT_UNITS = 196
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] addr,
    input  logic [7:0]  cmd,
    output logic        busy,
    output logic        done,
    output logic        env,
    output logic        ir_out
);

    localparam int unsigned UNIT_CYC    = (CLK_HZ * 9) / 16000;
    localparam int unsigned CAR_DIV     = CLK_HZ / CARRIER_HZ;
    localparam int unsigned CAR_HI      = (CAR_DIV * DUTY_PCT) / 100;
    // Longest legal full frame (all ones) bounds the period count when REPEAT_UNITS is small.
    localparam int unsigned FRAME_MAX   = 16 + 8 + 32 * 4 + 1;
    localparam int unsigned PER_MAX     = (REPEAT_UNITS > FRAME_MAX) ? REPEAT_UNITS : FRAME_MAX;
    localparam int unsigned UNIT_W      = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int unsigned CAR_W       = (CAR_DIV > 1) ? $clog2(CAR_DIV) : 1;
    localparam int unsigned PER_W       = $clog2(PER_MAX + 2);
    localparam int unsigned SEG_W       = $clog2(16);
    localparam int unsigned BIT_W       = $clog2(32);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        RPT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [UNIT_W-1:0]  unit_q, unit_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [CAR_W-1:0]   car_q, car_d;
    logic [31:0]        pay_q, pay_d;
    logic               rpt_q, rpt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               env_q, env_d;
    logic               ir_q, ir_d;

    logic               tick_c;
    logic               seg_end_c;
    logic               mark_c;
    logic [7:0]         b1_c;

`ifdef IR_NEC_TX_EXT_ADDR_EN
    assign b1_c = addr[15:8];
`else
    logic unused_addr_hi_c;
    assign unused_addr_hi_c = ^addr[15:8];
    assign b1_c = ~addr[7:0];
`endif

    // Next-state, counters and registered outputs
    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        bit_d     = bit_q;
        pay_d     = pay_q;
        rpt_d     = rpt_q;
        unit_d    = unit_q;
        per_d     = per_q;
        car_d     = car_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        env_d     = 1'b0;
        ir_d      = 1'b0;
        mark_c    = 1'b0;

        tick_c    = (unit_q == UNIT_W'(UNIT_CYC - 1));
        seg_end_c = tick_c && (seg_q == '0);
        if (tick_c && (seg_q != '0)) begin
            seg_d = seg_q - SEG_W'(1);
        end

        // seg_q holds remaining units minus one for the current mark/space
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LEAD_MARK;
                    seg_d   = SEG_W'(15);
                    rpt_d   = 1'b0;
                    pay_d   = {~cmd, cmd, b1_c, addr[7:0]};
                end
            end
            LEAD_MARK: begin
                if (seg_end_c) begin
                    state_d = rpt_q ? RPT_SPACE : LEAD_SPACE;
                    seg_d   = rpt_q ? SEG_W'(3) : SEG_W'(7);
                end
            end
            LEAD_SPACE: begin
                if (seg_end_c) begin
                    state_d = BIT_MARK;
                    seg_d   = '0;
                    bit_d   = '0;
                end
            end
            BIT_MARK: begin
                if (seg_end_c) begin
                    state_d = BIT_SPACE;
                    seg_d   = pay_q[0] ? SEG_W'(2) : SEG_W'(0);
                end
            end
            BIT_SPACE: begin
                if (seg_end_c) begin
                    pay_d   = {1'b0, pay_q[31:1]};
                    seg_d   = '0;
                    if (bit_q == BIT_W'(31)) begin
                        state_d = STOP_MARK;
                        bit_d   = '0;
                    end else begin
                        state_d = BIT_MARK;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            RPT_SPACE: begin
                if (seg_end_c) begin
                    state_d = STOP_MARK;
                    seg_d   = '0;
                end
            end
            STOP_MARK: begin
                if (seg_end_c) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (!start) begin
                    state_d = IDLE;
                end else if (tick_c && (per_q >= PER_W'(REPEAT_UNITS - 1))) begin
                    state_d = LEAD_MARK;
                    seg_d   = SEG_W'(15);
                    rpt_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Unit phase is held at zero in IDLE so every frame starts on a unit boundary
        if ((state_q == IDLE) || (state_d == IDLE) || tick_c) begin
            unit_d = '0;
        end else begin
            unit_d = unit_q + UNIT_W'(1);
        end

        if ((state_d == IDLE) || ((state_d == LEAD_MARK) && (state_q != LEAD_MARK))) begin
            per_d = '0;
        end else if (tick_c) begin
            per_d = per_q + PER_W'(1);
        end

        mark_c = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);

        // Carrier phase restarts at every mark entry so each mark opens with a high cycle
        if (!mark_c || (state_d != state_q) || (car_q == CAR_W'(CAR_DIV - 1))) begin
            car_d = '0;
        end else begin
            car_d = car_q + CAR_W'(1);
        end

        busy_d = (state_d != IDLE);
        env_d  = mark_c;
        ir_d   = mark_c && (32'(car_d) < CAR_HI);
        done_d = (state_d == STOP_MARK) && (seg_d == '0) && (unit_d == UNIT_W'(UNIT_CYC - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            unit_q  <= '0;
            seg_q   <= '0;
            bit_q   <= '0;
            per_q   <= '0;
            car_q   <= '0;
            pay_q   <= '0;
            rpt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            env_q   <= 1'b0;
            ir_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            seg_q   <= seg_d;
            bit_q   <= bit_d;
            per_q   <= per_d;
            car_q   <= car_d;
            pay_q   <= pay_d;
            rpt_q   <= rpt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            env_q   <= env_d;
            ir_q    <= ir_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign env    = env_q;
    assign ir_out = ir_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Directed self-checking bench for ir_nec_tx: envelope decoding, timing, carrier, repeats, reset.
// Scaled clock keeps the run short: 36 cycles per unit, 40-cycle carrier with 12 high cycles.
module tb_ir_nec_tx;

    localparam int unsigned CLK_HZ       = 64_000;
    localparam int unsigned CARRIER_HZ   = 1_600;
    localparam int unsigned DUTY_PCT     = 30;
    localparam int unsigned REPEAT_UNITS = 196;

    localparam int UNIT       = 36;
    localparam int CAR        = 40;
    localparam int CAR_HI     = 12;
    localparam int RPT_PERIOD = 7056;

`ifdef IR_NEC_TX_EXT_ADDR_EN
    localparam int          FULL_UNITS = 105;
    localparam logic [31:0] PL_A5      = 32'h5AA5_0000;
    localparam logic [31:0] PL_T4      = 32'hF00F_00C3;
    localparam logic [31:0] PL_OLD     = 32'hC33C_12AB;
    localparam logic [31:0] PL_NEW     = 32'h7E81_5AFF;
`else
    localparam int          FULL_UNITS = 121;
    localparam logic [31:0] PL_A5      = 32'h5AA5_FF00;
    localparam logic [31:0] PL_T4      = 32'hF00F_3CC3;
    localparam logic [31:0] PL_OLD     = 32'hC33C_54AB;
    localparam logic [31:0] PL_NEW     = 32'h7E81_00FF;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        busy;
    logic        done;
    logic        env;
    logic        ir_out;

    int checks   = 0;
    int failures = 0;

    ir_nec_tx #(
        .CLK_HZ      (CLK_HZ),
        .CARRIER_HZ  (CARRIER_HZ),
        .DUTY_PCT    (DUTY_PCT),
        .REPEAT_UNITS(REPEAT_UNITS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .addr  (addr),
        .cmd   (cmd),
        .busy  (busy),
        .done  (done),
        .env   (env),
        .ir_out(ir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Envelope run recorder plus per-cycle carrier model
    int   cyc       = 0;
    logic mon_env   = 1'b0;
    int   run_cur   = 0;
    int   run_beg   = 0;
    int   mark_pos  = 0;
    int   car_err   = 0;
    int   done_cnt  = 0;
    int   done_cyc  = 0;
    int   busy_fall = 0;
    logic prev_busy = 1'b0;
    logic exp_ir;
    logic run_lvl[$];
    int   run_len[$];
    int   run_start[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (env !== mon_env) begin
            run_lvl.push_back(mon_env);
            run_len.push_back(run_cur);
            run_start.push_back(run_beg);
            mon_env  = env;
            run_cur  = 1;
            run_beg  = cyc;
            mark_pos = 0;
        end else begin
            run_cur  = run_cur + 1;
            mark_pos = mark_pos + 1;
        end
        exp_ir = (env === 1'b1) && ((mark_pos % CAR) < CAR_HI);
        if (ir_out !== exp_ir) car_err = car_err + 1;
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (prev_busy === 1'b1 && busy === 1'b0) busy_fall = cyc;
        prev_busy = busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_marks(input int n, input int bound, input string tag);
        int   seen;
        int   c;
        logic p;
        seen = 0;
        c    = 0;
        p    = env;
        while (seen < n && c < bound) begin
            step();
            c++;
            if (env === 1'b1 && p !== 1'b1) seen++;
            p = env;
        end
        check(tag, seen, n);
    endtask

    task automatic wait_env_low(input int bound, input string tag);
        int c;
        c = 0;
        while (env !== 1'b0 && c < bound) begin
            step();
            c++;
        end
        check(tag, 32'(env), 32'd0);
    endtask

    // Decode the full frame whose lead mark is the first high run recorded at or after base
    task automatic decode(input int base, output int k, output int nm,
                          output logic [31:0] pl, output int bad);
        int n;
        n   = run_lvl.size();
        k   = base;
        nm  = 0;
        pl  = '0;
        bad = 0;
        while (k < n && run_lvl[k] !== 1'b1) k++;
        for (int i = base; i < n; i++) begin
            if (run_lvl[i] === 1'b1) nm++;
        end
        if (k + 66 >= n) begin
            bad = 1000;
        end else begin
            if (run_len[k] != 16 * UNIT) bad++;
            if (run_len[k+1] != 8 * UNIT) bad++;
            for (int b = 0; b < 32; b++) begin
                if (run_len[k+2+2*b] != UNIT) bad++;
                if (run_len[k+3+2*b] == 3 * UNIT) pl[b] = 1'b1;
                else if (run_len[k+3+2*b] != UNIT) bad++;
            end
            if (run_len[k+66] != UNIT) bad++;
        end
    endtask

    initial begin
        int          base;
        int          k;
        int          nm;
        int          bad;
        int          t0;
        int          d0;
        int          c0;
        logic [31:0] pl;

        rst   = 1'b1;
        start = 1'b0;
        addr  = '0;
        cmd   = '0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_env", 32'(env), 32'd0);
        check("rst_ir", 32'(ir_out), 32'd0);
        rst = 1'b0;
        repeat (50) step();
        check("idle_env", 32'(env), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Full frame from a one-cycle start pulse
        base  = run_lvl.size();
        d0    = done_cnt;
        c0    = car_err;
        addr  = 16'h0000;
        cmd   = 8'hA5;
        start = 1'b1;
        step();
        check("full_lat_env", 32'(env), 32'd1);
        check("full_lat_busy", 32'(busy), 32'd1);
        t0    = cyc;
        start = 1'b0;
        wait_idle(6000, "full_idle");
        decode(base, k, nm, pl, bad);
        check("full_marks", nm, 34);
        check("full_payload", pl, PL_A5);
        check("full_shape", bad, 0);
        check("full_done_cnt", done_cnt - d0, 1);
        check("full_done_cyc", done_cyc - t0, FULL_UNITS * UNIT - 1);
        check("full_busy_fall", busy_fall - t0, FULL_UNITS * UNIT + 1);
        check("full_carrier", car_err - c0, 0);

        // Held start: one full frame followed by two repeat frames
        repeat (5) step();
        base  = run_lvl.size();
        d0    = done_cnt;
        start = 1'b1;
        step();
        t0 = cyc;
        while (cyc < t0 + 2 * RPT_PERIOD + 21 * UNIT + 10) step();
        start = 1'b0;
        wait_idle(100, "rpt_idle");
        decode(base, k, nm, pl, bad);
        check("rpt_marks", nm, 38);
        check("rpt_full_payload", pl, PL_A5);
        check("rpt1_start", run_start[k+68] - t0, RPT_PERIOD);
        check("rpt1_mark", run_len[k+68], 16 * UNIT);
        check("rpt1_space", run_len[k+69], 4 * UNIT);
        check("rpt1_stop", run_len[k+70], UNIT);
        check("rpt2_start", run_start[k+72] - t0, 2 * RPT_PERIOD);
        check("rpt2_mark", run_len[k+72], 16 * UNIT);
        check("rpt2_space", run_len[k+73], 4 * UNIT);
        check("rpt2_stop", run_len[k+74], UNIT);
        check("rpt_done_cnt", done_cnt - d0, 3);

        // Reset during the space of bit 10
        repeat (5) step();
        addr  = 16'h00C3;
        cmd   = 8'h0F;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_marks(11, 3000, "mid_bit10_mark");
        wait_env_low(200, "mid_bit10_space");
        step();
        check("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_env", 32'(env), 32'd0);
        check("mid_rst_ir", 32'(ir_out), 32'd0);
        repeat (3) step();
        rst = 1'b0;
        repeat (100) step();
        check("mid_post_busy", 32'(busy), 32'd0);
        check("mid_post_env", 32'(env), 32'd0);

        // Release from reset with start already high
        rst = 1'b1;
        step();
        base  = run_lvl.size();
        d0    = done_cnt;
        start = 1'b1;
        #1;
        rst = 1'b0;
        step();
        check("restart_env", 32'(env), 32'd1);
        check("restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_idle(6000, "restart_idle");
        decode(base, k, nm, pl, bad);
        check("restart_marks", nm, 34);
        check("restart_payload", pl, PL_T4);
        check("restart_done_cnt", done_cnt - d0, 1);

        // Inputs changed mid-frame must not disturb the frame in flight
        repeat (5) step();
        base  = run_lvl.size();
        addr  = 16'h12AB;
        cmd   = 8'h3C;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_marks(19, 4000, "chg_mid");
        addr = 16'h5AFF;
        cmd  = 8'h81;
        wait_idle(6000, "chg_idle");
        decode(base, k, nm, pl, bad);
        check("chg_old_payload", pl, PL_OLD);
        check("chg_old_shape", bad, 0);

        repeat (5) step();
        base  = run_lvl.size();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(6000, "chg_new_idle");
        decode(base, k, nm, pl, bad);
        check("chg_new_payload", pl, PL_NEW);
        check("chg_new_shape", bad, 0);

        check("carrier_total", car_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
